// File: rtl/gold_pkg.sv
// Shared types and helpers for the Gold-code generator.
//   state_e   : top-level FSM states (ALIGN, RUN)
//   period    : m-sequence period 2^width-1
//   lfsr_next : one Fibonacci LFSR step on a MAX_W-wide container;
//               bits at and above 'width' must be zero on entry.
package gold_pkg;

  typedef enum logic {
    ALIGN = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Widest legal LFSR; the step helper works on this container width.
  localparam int MAX_W = 16;

  function automatic int period(input int width);
    return (1 << width) - 1;
  endfunction

  // f = parity of tapped bits; it enters at the MSB while the register
  // shifts right, so the chip is always bit 0.
  function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] s,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int               width);
    logic f;
    f = ^(s & poly);
    return (s >> 1) | (MAX_W'(f) << (width - 1));
  endfunction

endpackage

// File: rtl/gold_code_gen_p_if.sv
// Bus bundle for gold_code_gen_p.
//   cfg_*    : configuration offer (valid/ready), polys, seeds, shift
//   out_*    : chip stream (valid/ready), chip bit, epoch marker, index
//   seed_err : sticky zero-seed flag
// master = generator side, slave = configuration source / chip consumer.
interface gold_code_gen_p_if #(
  parameter int WIDTH = 5
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_poly1;
  logic [WIDTH-1:0] cfg_poly2;
  logic [WIDTH-1:0] cfg_seed1;
  logic [WIDTH-1:0] cfg_seed2;
  logic [WIDTH-1:0] cfg_shift;

  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_epoch;
  logic [WIDTH-1:0] out_index;
  logic             seed_err;

  modport master (
    input  cfg_valid, cfg_poly1, cfg_poly2, cfg_seed1, cfg_seed2, cfg_shift,
    input  out_ready,
    output cfg_ready,
    output out_valid, out_bit, out_epoch, out_index, seed_err
  );

  modport slave (
    output cfg_valid, cfg_poly1, cfg_poly2, cfg_seed1, cfg_seed2, cfg_shift,
    output out_ready,
    input  cfg_ready,
    input  out_valid, out_bit, out_epoch, out_index, seed_err
  );

endinterface

// File: rtl/gold_code_gen_p_mseq_lfsr.sv
// One Fibonacci LFSR producing an m-sequence chip stream.
//   clk_i      : clock
//   load_i     : load seed/poly (wins over step_i); also used as reset load
//   step_i     : advance one chip
//   seed_i     : seed to load; zero is replaced by 1
//   poly_i     : tap polynomial without the leading 1
//   chip_o     : current chip (state bit 0)
//   zero_fix_o : high in the load cycle when the seed had to be replaced
// No reset of its own: the parent asserts load_i with default values while
// its reset is held, so register init stays in one place.
module mseq_lfsr
  import gold_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [WIDTH-1:0] poly_i,
  output logic             chip_o,
  output logic             zero_fix_o
);

  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] poly_q, poly_d;
  logic [WIDTH-1:0] seed_fix;
  logic [WIDTH-1:0] s_step;

  // All-zero is the LFSR lock-up state; substitute the smallest legal seed.
  assign seed_fix   = (seed_i == '0) ? WIDTH'(1) : seed_i;
  assign zero_fix_o = load_i && (seed_i == '0);
  assign s_step     = WIDTH'(lfsr_next(MAX_W'(s_q), MAX_W'(poly_q), WIDTH));
  assign chip_o     = s_q[0];

  always_comb begin
    s_d    = s_q;
    poly_d = poly_q;
    if (load_i) begin
      s_d    = seed_fix;
      poly_d = poly_i;
    end else if (step_i) begin
      s_d    = s_step;
    end
  end

  always_ff @(posedge clk_i) begin
    s_q    <= s_d;
    poly_q <= poly_d;
  end

endmodule

// File: rtl/gold_code_gen_p.sv
// Parametrised Gold-code chip generator.
//   clkin : clock
//   rstn  : synchronous active-low reset
//   bus   : gold_code_gen_p_if master (config handshake, chip stream,
//           seed_err)
// Two m-sequence LFSRs are XORed chip-wise. After reset or an accepted
// config the FSM sits in ALIGN, advancing LFSR2 by the requested shift, then
// streams chips in RUN with an index 0..P-1 and an epoch marker on index 0.
module gold_code_gen_p
  import gold_pkg::*;
#(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] POLY1_DEF = WIDTH'(5'b00101),
  parameter logic [WIDTH-1:0] POLY2_DEF = WIDTH'(5'b01101),
  parameter logic [WIDTH-1:0] SEED1_DEF = WIDTH'(5'b01010),
  parameter logic [WIDTH-1:0] SEED2_DEF = WIDTH'(5'b01110),
  parameter logic [WIDTH-1:0] SHIFT_DEF = '0
) (
  input  logic               clkin,
  input  logic               rstn,
  gold_code_gen_p_if.master  bus
);

  localparam int               P    = period(WIDTH);
  localparam logic [WIDTH-1:0] P_W  = WIDTH'(P);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(P - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic             err_q, err_d;

  logic             run, accept, fire;
  logic             load, step1, step2;
  logic             chip1, chip2, zf1, zf2;
  logic [WIDTH-1:0] seed1, seed2, poly1, poly2, shift_cfg;

  assign run    = (state_q == RUN);
  assign accept = run & bus.cfg_valid;
  assign fire   = run & bus.out_ready;

  // Reset reuses the LFSR load path with the default values.
  assign load  = !rstn || accept;
  assign seed1 = rstn ? bus.cfg_seed1 : SEED1_DEF;
  assign seed2 = rstn ? bus.cfg_seed2 : SEED2_DEF;
  assign poly1 = rstn ? bus.cfg_poly1 : POLY1_DEF;
  assign poly2 = rstn ? bus.cfg_poly2 : POLY2_DEF;

  // cfg_shift can only reach P itself, so one subtraction gives shift mod P.
  assign shift_cfg = (bus.cfg_shift >= P_W) ? bus.cfg_shift - P_W : bus.cfg_shift;

  // A config accept consumes the presented chip but the LFSRs load rather
  // than step (load wins inside mseq_lfsr as well).
  assign step1 = fire && !accept;
  assign step2 = (!run && shift_q != '0) || (fire && !accept);

  mseq_lfsr #(.WIDTH(WIDTH)) u_lfsr1 (
    .clk_i      (clkin),
    .load_i     (load),
    .step_i     (step1),
    .seed_i     (seed1),
    .poly_i     (poly1),
    .chip_o     (chip1),
    .zero_fix_o (zf1)
  );

  mseq_lfsr #(.WIDTH(WIDTH)) u_lfsr2 (
    .clk_i      (clkin),
    .load_i     (load),
    .step_i     (step2),
    .seed_i     (seed2),
    .poly_i     (poly2),
    .chip_o     (chip2),
    .zero_fix_o (zf2)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    err_d   = err_q;
    if (state_q == ALIGN) begin
      if (shift_q != '0) shift_d = shift_q - WIDTH'(1);
      else               state_d = RUN;
    end else begin
      if (accept) begin
        shift_d = shift_cfg;
        idx_d   = '0;
        // Sticky flag is rewritten by every accepted config.
        err_d   = zf1 | zf2;
        state_d = ALIGN;
      end else if (fire) begin
        idx_d   = (idx_q == LAST) ? '0 : idx_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (!rstn) begin
      state_q <= ALIGN;
      shift_q <= SHIFT_DEF;
      idx_q   <= '0;
      // Non-zero defaults leave this low; a zero default seed is flagged.
      err_q   <= zf1 | zf2;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign bus.cfg_ready = run;
  assign bus.out_valid = run;
  assign bus.out_bit   = chip1 ^ chip2;
  assign bus.out_index = idx_q;
  assign bus.out_epoch = run && (idx_q == '0);
  assign bus.seed_err  = err_q;

endmodule
